// File: rtl/mips_pkg.sv
// Shared datapath constants and types for the MIPS register file slice.
package mips_pkg;

  localparam int unsigned ANCHO_DATO = 32;
  localparam int unsigned ANCHO_DIR  = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [4:0] REG_CERO = 5'd0;

  typedef logic [4:0]  dir_reg_t;
  typedef logic [31:0] palabra_t;

endpackage

// File: rtl/decodificador_5a32.sv
// One-hot write-enable decoder for the register file; entry 0 never loads.
module decodificador_5a32
  import mips_pkg::*;
#(
  parameter int unsigned ANCHO_SEL = ANCHO_DIR
) (
  input  logic                      EscrReg,
  input  logic [ANCHO_SEL-1:0]      Dir_Escritura,
  output logic [(2**ANCHO_SEL)-1:0] habilita_c
);

  // Address is only decoded under EscrReg so an unknown address while idle enables nothing.
  always_comb begin
    habilita_c = '0;
    if (EscrReg) begin
      habilita_c[Dir_Escritura] = 1'b1;
    end
    habilita_c[ANCHO_SEL'(REG_CERO)] = 1'b0;
  end

endmodule

// File: rtl/banco_registros_32x32.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one synchronous write port, hardwired-zero r0 and a committed-write counter.
module banco_registros_32x32 #(
  parameter int unsigned ANCHO_DATO = mips_pkg::ANCHO_DATO,
  parameter int unsigned ANCHO_DIR  = mips_pkg::ANCHO_DIR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  EscrReg,
  input  logic [ANCHO_DIR-1:0]  Dir_Escritura,
  input  logic [ANCHO_DATO-1:0] Dato_Escritura,
  input  logic [ANCHO_DIR-1:0]  Dir_Lectura_1,
  input  logic [ANCHO_DIR-1:0]  Dir_Lectura_2,
  output logic [ANCHO_DATO-1:0] Dato_Lectura_1,
  output logic [ANCHO_DATO-1:0] Dato_Lectura_2,
  output logic                  Escritura_Valida,
  output logic [15:0]           Cuenta_Escrituras
);
  import mips_pkg::*;

  localparam int unsigned NUM_ENTRADAS = 2**ANCHO_DIR;
  localparam int unsigned ANCHO_CUENTA = 16;

  logic [NUM_ENTRADAS-1:0] habilita_c;
  logic [ANCHO_DATO-1:0]   regs_q [NUM_ENTRADAS];
  logic [ANCHO_DATO-1:0]   regs_d [NUM_ENTRADAS];
  logic                    valido_q;
  logic                    valido_d;
  logic [ANCHO_CUENTA-1:0] cuenta_q;
  logic [ANCHO_CUENTA-1:0] cuenta_d;
  logic                    bypass_1_c;
  logic                    bypass_2_c;

  decodificador_5a32 #(
    .ANCHO_SEL (ANCHO_DIR)
  ) u_decodificador (
    .EscrReg       (EscrReg),
    .Dir_Escritura (Dir_Escritura),
    .habilita_c    (habilita_c)
  );

  // Any set enable bit means a write to a nonzero address commits on this edge.
  always_comb begin
    regs_d   = regs_q;
    valido_d = |habilita_c;
    cuenta_d = cuenta_q + ANCHO_CUENTA'(valido_d);
    for (int i = 0; i < int'(NUM_ENTRADAS); i++) begin
      if (habilita_c[i]) begin
        regs_d[i] = Dato_Escritura;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_ENTRADAS); i++) begin
        regs_q[i] <= '0;
      end
      valido_q <= 1'b0;
      cuenta_q <= '0;
    end else begin
      regs_q   <= regs_d;
      valido_q <= valido_d;
      cuenta_q <= cuenta_d;
    end
  end

  // Bypass is suppressed under reset so the read ports settle to zero immediately.
  assign bypass_1_c = EscrReg && !reset && (Dir_Escritura == Dir_Lectura_1);
  assign bypass_2_c = EscrReg && !reset && (Dir_Escritura == Dir_Lectura_2);

  always_comb begin
    Dato_Lectura_1 = regs_q[Dir_Lectura_1];
    if (bypass_1_c) begin
      Dato_Lectura_1 = Dato_Escritura;
    end
    if (Dir_Lectura_1 == ANCHO_DIR'(REG_CERO)) begin
      Dato_Lectura_1 = '0;
    end
  end

  always_comb begin
    Dato_Lectura_2 = regs_q[Dir_Lectura_2];
    if (bypass_2_c) begin
      Dato_Lectura_2 = Dato_Escritura;
    end
    if (Dir_Lectura_2 == ANCHO_DIR'(REG_CERO)) begin
      Dato_Lectura_2 = '0;
    end
  end

  assign Escritura_Valida  = valido_q;
  assign Cuenta_Escrituras = cuenta_q;

endmodule

// File: tb/tb_banco_registros_32x32.sv
// Scoreboard bench for banco_registros_32x32 against an array-based reference model.
module tb_banco_registros_32x32;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        EscrReg;
  dir_reg_t    Dir_Escritura;
  palabra_t    Dato_Escritura;
  dir_reg_t    Dir_Lectura_1;
  dir_reg_t    Dir_Lectura_2;
  palabra_t    Dato_Lectura_1;
  palabra_t    Dato_Lectura_2;
  logic        Escritura_Valida;
  logic [15:0] Cuenta_Escrituras;

  banco_registros_32x32 dut (
    .clk               (clk),
    .reset             (reset),
    .EscrReg           (EscrReg),
    .Dir_Escritura     (Dir_Escritura),
    .Dato_Escritura    (Dato_Escritura),
    .Dir_Lectura_1     (Dir_Lectura_1),
    .Dir_Lectura_2     (Dir_Lectura_2),
    .Dato_Lectura_1    (Dato_Lectura_1),
    .Dato_Lectura_2    (Dato_Lectura_2),
    .Escritura_Valida  (Escritura_Valida),
    .Cuenta_Escrituras (Cuenta_Escrituras)
  );

  always #5 clk = ~clk;

  typedef struct {
    palabra_t    r1;
    palabra_t    r2;
    logic        v;
    logic [15:0] c;
    string       tag;
  } esperado_t;

  esperado_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  palabra_t    mem [32];
  logic        v_m;
  logic [15:0] c_m;

  function automatic palabra_t ref_read(input dir_reg_t ra);
    if (ra == 5'd0) return '0;
    if (reset === 1'b1) return '0;
    if (EscrReg === 1'b1 && Dir_Escritura === ra) return Dato_Escritura;
    return mem[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    v_m = 1'b0;
    c_m = '0;
  endtask

  task automatic push_exp(input string tag);
    esperado_t e;
    e.r1 = ref_read(Dir_Lectura_1);
    e.r2 = ref_read(Dir_Lectura_2);
    e.v = v_m;
    e.c = c_m;
    e.tag = tag;
    q.push_back(e);
  endtask

  // One cycle: drive inputs just after a rising edge, queue expectation, advance model on the edge.
  task automatic drive(input logic we, input dir_reg_t wa, input palabra_t wd,
                       input dir_reg_t a1, input dir_reg_t a2, input string tag);
    EscrReg = we;
    Dir_Escritura = wa;
    Dato_Escritura = wd;
    Dir_Lectura_1 = a1;
    Dir_Lectura_2 = a2;
    push_exp(tag);
    @(posedge clk);
    if (reset !== 1'b1) begin
      if (we === 1'b1 && wa !== 5'd0) begin
        mem[wa] = wd;
        v_m = 1'b1;
        c_m = c_m + 16'd1;
      end else begin
        v_m = 1'b0;
      end
    end
    #1;
  endtask

  // Reset asserted mid-cycle with a write pending; that write must be lost.
  task automatic reset_pulse(input string tag);
    EscrReg = 1'b1;
    Dir_Escritura = 5'd6;
    Dato_Escritura = 32'hCAFE_F00D;
    Dir_Lectura_1 = 5'd5;
    Dir_Lectura_2 = 5'd6;
    #2;
    reset = 1'b1;
    model_clear();
    push_exp(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp_v);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the state-updating edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      esperado_t e;
      e = q.pop_front();
      cmp({e.tag, ".rd1"},   Dato_Lectura_1, e.r1);
      cmp({e.tag, ".rd2"},   Dato_Lectura_2, e.r2);
      cmp({e.tag, ".valid"}, 32'(Escritura_Valida), 32'(e.v));
      cmp({e.tag, ".count"}, 32'(Cuenta_Escrituras), 32'(e.c));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    dir_reg_t wa, a1, a2;
    reset = 1'b1;
    EscrReg = 1'b0;
    Dir_Escritura = '0;
    Dato_Escritura = '0;
    Dir_Lectura_1 = '0;
    Dir_Lectura_2 = '0;
    model_clear();
    @(posedge clk);
    #1;
    drive(1'b1, 5'd9, 32'h1111_1111, 5'd9, 5'd17, "rst_init");
    reset = 1'b0;

    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0, "t1_wr");
    drive(1'b0, 5'd0, '0, 5'd5, 5'd5, "t1_rd");
    reset_pulse("t1_reset");
    drive(1'b0, 5'd0, '0, 5'd5, 5'd6, "t1_after");

    drive(1'b1, 5'd17, 32'h0000_1234, 5'd0, 5'd0, "t2_wr");
    drive(1'b0, 5'd0, '0, 5'd17, 5'd0, "t2_rd");
    drive(1'b0, 5'd0, '0, 5'd17, 5'd17, "t2_rd2");

    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, "t3_wr0");
    drive(1'b0, 5'd0, '0, 5'd0, 5'd0, "t3_rd0");

    drive(1'b1, 5'd31, 32'hA5A5_A5A5, 5'd0, 5'd31, "t4_bypass");
    drive(1'b0, 5'd0, '0, 5'd31, 5'd31, "t4_stored");

    drive(1'b1, 5'd3, 32'h0000_0077, 5'd3, 5'd0, "t5_init");
    for (int k = 0; k < 4; k++) drive(1'b0, 5'd3, 32'h1, 5'd3, 5'd3, "t5_dis");
    drive(1'b0, 5'bxxxxx, 32'hFFFF_0000, 5'd3, 5'd31, "t5_xaddr");
    drive(1'b0, 5'd0, '0, 5'd3, 5'd31, "t5_after_x");

    for (int i = 1; i < 32; i++)
      drive(1'b1, 5'(i), 32'(i) * 32'h0101_0101, 5'(i), 5'(31 - i), "t6_wr");
    for (int i = 0; i < 32; i++)
      drive(1'b0, 5'd0, '0, 5'(i), 5'(31 - i), "t6_sweep");

    for (int k = 0; k < 400; k++) begin
      wa = 5'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      drive(1'($urandom_range(0, 1)), wa, $urandom, a1, a2, "rand");
    end

    reset_pulse("wrap_reset");
    for (int k = 0; k < 65536; k++)
      drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom), 5'($urandom), "wrap");
    drive(1'b0, 5'd0, '0, 5'd1, 5'd2, "wrap_end");

    repeat (2) @(negedge clk);
    #1;
    cmp("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
